wb_trace_fifo: RTL and testbench
================================

// Module: wb_trace_fifo
// PURPOSE
//   Sits directly downstream of the CPU's debug writeback port. Captures each
//   register-file write into a first-word-fall-through FIFO: PC, byte enables,
//   register number, write data and a sequence number.
//   Drains entries over a valid/ready port to the trace comparator or trace dump
//   logic. This decouples the single-cycle writeback strobe from a comparator
//   that can stall.
// PARAMETERS
//   ADDR_W     4    log2 of FIFO depth; DEPTH = 2**ADDR_W entries (default 16)
//   FILTER_R0  1    1: drop writes whose wnum==0 without capturing them; 0: capture them
//   SEQ_W      16   sequence-number width
// PORTS
//   clk          in   1       clock; all state updates on rising edge
//   rst          in   1       asynchronous, active-high reset
//   wb_pc        in   32      debug writeback PC
//   wb_rf_wen    in   4       debug writeback byte enables; capture request when any bit is set
//   wb_rf_wnum   in   5       debug writeback destination register
//   wb_rf_wdata  in   32      debug writeback data
//   clear        in   1       synchronous flush of the FIFO and sticky flags
//   out_valid    out  1       head entry valid
//   out_ready    in   1       consumer accepts the head entry when out_valid && out_ready
//   out_pc       out  32      head PC
//   out_wen      out  4       head byte enables
//   out_wnum     out  5       head register number
//   out_wdata    out  32      head data; byte lanes with wen=0 forced to 0
//   out_seq      out  SEQ_W   head sequence number
//   count        out  ADDR_W+1  current occupancy, 0..DEPTH
//   full         out  1       count==DEPTH
//   empty        out  1       count==0
//   overflow     out  1       sticky: at least one capture was dropped because the FIFO was full
// BEHAVIOUR
//   Reset (async, rst=1)
//     - Pointers, count, seq counter and overflow all 0.
//     - out_valid=0, empty=1, full=0; all out_* data fields 0.
//   Capture
//     - push_req = |wb_rf_wen && !(FILTER_R0 && wb_rf_wnum==0).
//     - Inputs are sampled in the cycle push_req is high.
//     - The entry is visible at the head on the next cycle when the FIFO was empty.
//       Latency is 1 clk from the capture edge to out_valid=1.
//   Pop
//     - pop = out_valid && out_ready.
//     - The next entry appears in the following cycle; out_* hold while out_valid && !out_ready.
//   Sequence counter
//     - seq increments by 1 on every push_req, whether the entry is accepted or dropped.
//     - The pushed entry carries the pre-increment value.
//     - seq wraps from 2**SEQ_W-1 to 0.
//     - The consumer detects drops as gaps in out_seq.
//   Simultaneous push and pop
//     - Both take effect and count is unchanged.
//     - This applies at full: the push is accepted, not dropped.
//     - It also applies at count==1: the new entry becomes the head next cycle and out_valid stays 1.
//   Full
//     - push_req with count==DEPTH and no pop: entry dropped, overflow<=1.
//     - FIFO contents are unchanged.
//   Empty
//     - out_valid=0; out_ready is ignored and count never underflows.
//   Pointers
//     - ADDR_W-bit read and write pointers wrap modulo DEPTH.
//     - full and empty are derived from count, not from pointer compare.
//   Clear
//     - Same effect as reset, but synchronous: pointers, count, overflow and seq go to 0 on the edge.
//     - clear has priority over push and pop in the same cycle; both are discarded.
//   Reset mid-operation
//     - All entries are lost and outputs return to reset values immediately, without waiting for clk.
// TESTING
//   1. Single write wen=4'hF, wnum=5, pc=32'hbfc00004, wdata=32'h1234 with out_ready=1
//      -> next cycle out_valid=1, out_seq=0 with the same fields; the following cycle out_valid=0.
//   2. FILTER_R0=1: write with wnum=0 -> nothing captured and count stays 0;
//      next write with wnum=3 -> out_seq=1, because the filtered write is not a push_req.
//   3. out_ready=0, 17 consecutive captures -> count=16, full=1, overflow=1.
//      Then drain with out_ready=1 -> out_seq 0..15 in order, then empty=1.
//   4. Fill to 16, then capture and out_ready=1 in the same cycle
//      -> count stays 16, overflow stays 0, and the new entry is delivered last.
//   5. wen=4'b0011, wdata=32'hAABBCCDD -> out_wdata=32'h0000CCDD, out_wen=4'b0011.
//   6. Assert rst asynchronously with count=5 -> out_valid=0 and count=0 before the next clk edge.
//      Separately, clear together with a capture -> count=0 and seq=0 next cycle.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures debug register-file writes into a
// first-word-fall-through queue drained over a valid/ready port.
module wb_trace_fifo #(
    parameter int ADDR_W    = 4,
    parameter int FILTER_R0 = 1,
    parameter int SEQ_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_pc,
    input  logic [3:0]        wb_rf_wen,
    input  logic [4:0]        wb_rf_wnum,
    input  logic [31:0]       wb_rf_wdata,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [3:0]        out_wen,
    output logic [4:0]        out_wnum,
    output logic [31:0]       out_wdata,
    output logic [SEQ_W-1:0]  out_seq,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    typedef struct packed {
        logic [31:0]      pc;
        logic [3:0]       wen;
        logic [4:0]       wnum;
        logic [31:0]      wdata;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              head;
    entry_t              entry_in;

    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                ovf_q, ovf_d;

    logic                is_r0;
    logic                push_req;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic [31:0]         lane_mask;

    // Request decode, handshake and the entry to be written.
    always_comb begin
        is_r0     = (FILTER_R0 != 0) && (wb_rf_wnum == 5'd0);
        push_req  = (|wb_rf_wen) && !is_r0;
        empty     = (count_q == '0);
        full      = (count_q == DEPTH_C);
        pop       = !empty && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok   = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        lane_mask = {{8{wb_rf_wen[3]}}, {8{wb_rf_wen[2]}},
                     {8{wb_rf_wen[1]}}, {8{wb_rf_wen[0]}}};
        entry_in.pc    = wb_pc;
        entry_in.wen   = wb_rf_wen;
        entry_in.wnum  = wb_rf_wnum;
        entry_in.wdata = wb_rf_wdata & lane_mask;
        entry_in.seq   = seq_q;
    end

    // Next-state for pointers, occupancy, sequence and sticky overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        seq_d   = seq_q;
        ovf_d   = ovf_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            seq_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push_req) begin
                seq_d = seq_q + 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage; contents are only observed through valid slots.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem_q[wptr_q] <= entry_in;
        end
    end

    // Head presentation, zeroed whenever no entry is valid.
    always_comb begin
        head      = mem_q[rptr_q];
        out_valid = !empty;
        out_pc    = out_valid ? head.pc    : '0;
        out_wen   = out_valid ? head.wen   : '0;
        out_wnum  = out_valid ? head.wnum  : '0;
        out_wdata = out_valid ? head.wdata : '0;
        out_seq   = out_valid ? head.seq   : '0;
        count     = count_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: vector table, scoreboard queue
// and directed multi-cycle sequences.
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_pc;
    logic [3:0]  wb_rf_wen;
    logic [4:0]  wb_rf_wnum;
    logic [31:0] wb_rf_wdata;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_wen;
    logic [4:0]  out_wnum;
    logic [31:0] out_wdata;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    wb_trace_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .wb_pc       (wb_pc),
        .wb_rf_wen   (wb_rf_wen),
        .wb_rf_wnum  (wb_rf_wnum),
        .wb_rf_wdata (wb_rf_wdata),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_wen     (out_wen),
        .out_wnum    (out_wnum),
        .out_wdata   (out_wdata),
        .out_seq     (out_seq),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [15:0] seq;
    } ent_t;

    typedef struct {
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] xwdata;
        int          xcount;
    } vec_t;

    ent_t sb[$];
    int   seq_m  = 0;
    bit   ovf_m  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] msk(input logic [3:0] w,
                                        input logic [31:0] d);
        return d & {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    endfunction

    // One clock: drive at negedge, check before the posedge, update model.
    task automatic cyc(input logic [3:0] wen, input logic [4:0] wnum,
                       input logic [31:0] pc, input logic [31:0] wd,
                       input logic [31:0] xwd, input logic rdy,
                       input logic clr);
        int   sz;
        bit   popm;
        bit   preq;
        ent_t e;
        @(negedge clk);
        wb_rf_wen   = wen;
        wb_rf_wnum  = wnum;
        wb_pc       = pc;
        wb_rf_wdata = wd;
        out_ready   = rdy;
        clear       = clr;
        #1;
        sz = sb.size();
        chk("valid", 32'(out_valid), 32'(sz != 0));
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == 16));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (sz == 0) begin
            chk("idle_pc", out_pc, 32'h0);
            chk("idle_data", out_wdata, 32'h0);
        end
        if (clr) begin
            sb.delete();
            seq_m = 0;
            ovf_m = 1'b0;
        end else begin
            popm = (sz != 0) && rdy;
            if (popm) begin
                e = sb.pop_front();
                chk("head_pc", out_pc, e.pc);
                chk("head_wen", 32'(out_wen), 32'(e.wen));
                chk("head_wnum", 32'(out_wnum), 32'(e.wnum));
                chk("head_wdata", out_wdata, e.wdata);
                chk("head_seq", 32'(out_seq), 32'(e.seq));
            end
            preq = (wen != 4'h0) && (wnum != 5'd0);
            if (preq) begin
                if (sz < 16 || popm) begin
                    e.pc    = pc;
                    e.wen   = wen;
                    e.wnum  = wnum;
                    e.wdata = xwd;
                    e.seq   = 16'(seq_m);
                    sb.push_back(e);
                end else begin
                    ovf_m = 1'b1;
                end
                seq_m = (seq_m + 1) & 32'hFFFF;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(4'h0, 5'd0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
        end
    endtask

    task automatic cap(input int i, input logic rdy);
        logic [4:0]  wn;
        logic [31:0] d;
        wn = 5'((i % 31) + 1);
        d  = 32'h5A00_0000 + 32'(i);
        cyc(4'hF, wn, 32'h8000_0000 + 32'(i * 4), d, d, rdy, 1'b0);
    endtask

    initial begin
        tbl[0] = '{4'hF, 5'd5, 32'hbfc00004, 32'h00001234, 1'b1,
                   32'h00001234, 1};
        tbl[1] = '{4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 0};
        tbl[2] = '{4'hF, 5'd0, 32'hbfc00008, 32'h11111111, 1'b1,
                   32'h0, 0};
        tbl[3] = '{4'b0001, 5'd3, 32'hbfc0000c, 32'hDEADBEEF, 1'b1,
                   32'h000000EF, 1};
        tbl[4] = '{4'b0011, 5'd7, 32'hbfc00010, 32'hAABBCCDD, 1'b1,
                   32'h0000CCDD, 1};
        tbl[5] = '{4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 0};
        tbl[6] = '{4'b1100, 5'd31, 32'hbfc00014, 32'hAABBCCDD, 1'b0,
                   32'hAABB0000, 1};

        rst         = 1'b1;
        clear       = 1'b0;
        wb_pc       = '0;
        wb_rf_wen   = '0;
        wb_rf_wnum  = '0;
        wb_rf_wdata = '0;
        out_ready   = 1'b0;
        #13;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_seq", 32'(out_seq), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].wen, tbl[i].wnum, tbl[i].pc, tbl[i].wdata,
                tbl[i].xwdata, tbl[i].rdy, 1'b0);
            #1;
            chk("tbl_count", 32'(count), 32'(tbl[i].xcount));
        end
        idle(1'b1, 2);

        cyc(4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            cap(i, 1'b0);
        end
        #1;
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_ovf", 32'(overflow), 32'h1);
        idle(1'b1, 17);
        #1;
        chk("drain_empty", 32'(empty), 32'h1);

        cyc(4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cap(i, 1'b0);
        end
        cap(99, 1'b1);
        #1;
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'h0);
        idle(1'b1, 17);

        for (int i = 0; i < 5; i++) begin
            cap(i + 40, 1'b0);
        end
        @(negedge clk);
        wb_rf_wen = 4'h0;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_empty", 32'(empty), 32'h1);
        chk("arst_pc", out_pc, 32'h0);
        sb.delete();
        seq_m = 0;
        ovf_m = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);

        cap(60, 1'b0);
        cap(61, 1'b0);
        cyc(4'hF, 5'd3, 32'hCAFE0000, 32'h1, 32'h1, 1'b0, 1'b1);
        #1;
        chk("clr_count", 32'(count), 32'h0);
        cap(62, 1'b0);
        idle(1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
